fir_share_arbiter: RTL and testbench

FIR_SHARE_ARBITER -- requirements
Module: fir_share_arbiter

---
 rtl/fir_share_pkg.sv | 15 +
 rtl/fir_share_rr.sv | 32 +++
 rtl/fir_share_arbiter.sv | 115 +++++++++++
 tb/tb_fir_share_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_share_pkg.sv
// Shared FSM encoding and default parameter values for the FIR sharing arbiter.
package fir_share_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'b00;
  localparam state_t STREAM = 2'b01;
  localparam state_t FREEZE = 2'b10;
  localparam state_t FLUSH  = 2'b11;

  localparam int DW_DEFAULT      = 16;
  localparam int PKT_LEN_DEFAULT = 12;
  localparam int IPD_DEFAULT     = 6;

endpackage

// File: rtl/fir_share_rr.sv
// 2-way grant logic for fir_share_arbiter. FIR_SHARE_RR_EN selects round-robin
// (with last-grant register); otherwise fixed priority, source 0 first.
module fir_share_rr (
`ifdef FIR_SHARE_RR_EN
  input  logic clk,
  input  logic Reset_n,
  input  logic grant_en,
`endif
  input  logic req0,
  input  logic req1,
  output logic grant
);

`ifdef FIR_SHARE_RR_EN
  logic last_grant;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last_grant;
    else if (req1)    grant = 1'b1;
  end

  // Resets to 1 so the first contested grant after reset goes to source 0.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)      last_grant <= 1'b1;
    else if (grant_en) last_grant <= grant;
  end
`else
  always_comb grant = req1 && !req0;
`endif

endmodule

// File: rtl/fir_share_arbiter.sv
// Shares one FIR input between two sample sources, packet by packet, with a
// zero-sample flush after each packet. Optional macro: FIR_SHARE_RR_EN.
module fir_share_arbiter
  import fir_share_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int PKT_LEN = PKT_LEN_DEFAULT,
  parameter int IPD     = IPD_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Valid0,
  input  logic          Valid1,
  input  logic [DW-1:0] X0,
  input  logic [DW-1:0] X1,
  output logic          Ready0,
  output logic          Ready1,
  input  logic          Hold,
  output logic          Valid_out,
  output logic [DW-1:0] X_out,
  output logic          Src_id,
  output logic          Packet_Done,
  output logic          Busy
);

  localparam int FW = $clog2(IPD + 1);

  state_t        state;
  logic [3:0]    count;
  logic [FW-1:0] flush_cnt;
  logic          src_id;
  logic          grant;
  logic          gnt_valid;
  logic [DW-1:0] gnt_x;
  logic          accept;

  always_comb begin
    gnt_valid = src_id ? Valid1 : Valid0;
    gnt_x     = src_id ? X1 : X0;
    Ready0    = (state == STREAM) && !Hold && !src_id;
    Ready1    = (state == STREAM) && !Hold &&  src_id;
    accept    = gnt_valid && (Ready0 || Ready1);
    Busy      = (state != IDLE);
    Src_id    = src_id;
  end

`ifdef FIR_SHARE_RR_EN
  logic grant_en;

  always_comb grant_en = (state == IDLE) && (Valid0 || Valid1);
`endif

  fir_share_rr u_rr (
`ifdef FIR_SHARE_RR_EN
    .clk      (clk),
    .Reset_n  (Reset_n),
    .grant_en (grant_en),
`endif
    .req0     (Valid0),
    .req1     (Valid1),
    .grant    (grant)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      count       <= '0;
      flush_cnt   <= '0;
      src_id      <= 1'b0;
      X_out       <= '0;
      Valid_out   <= 1'b0;
      Packet_Done <= 1'b0;
    end else begin
      Valid_out   <= 1'b0;
      Packet_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid0 || Valid1) begin
            src_id <= grant;
            count  <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          // Ready already folds in Hold, so a missed accept always means freeze.
          if (accept) begin
            X_out     <= gnt_x;
            Valid_out <= 1'b1;
            if (count == 4'(PKT_LEN - 1)) begin
              count       <= '0;
              Packet_Done <= 1'b1;
              flush_cnt   <= '0;
              state       <= FLUSH;
            end else begin
              count <= count + 4'd1;
            end
          end else begin
            state <= FREEZE;
          end
        end
        FREEZE: begin
          if (!Hold && gnt_valid) state <= STREAM;
        end
        FLUSH: begin
          X_out     <= '0;
          Valid_out <= 1'b1;
          if (flush_cnt == FW'(IPD - 1)) state <= IDLE;
          else                           flush_cnt <= flush_cnt + FW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_share_arbiter.sv
// Self-checking bench for fir_share_arbiter: table of packet scenarios plus a
// mid-packet reset sequence; output samples are checked against a scoreboard queue.
module tb_fir_share_arbiter;
  import fir_share_pkg::*;

  localparam int DW      = DW_DEFAULT;
  localparam int PKT_LEN = PKT_LEN_DEFAULT;
  localparam int IPD     = IPD_DEFAULT;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          Valid0, Valid1, Hold;
  logic [DW-1:0] X0, X1;
  logic          Ready0, Ready1, Valid_out, Src_id, Packet_Done, Busy;
  logic [DW-1:0] X_out;

  fir_share_arbiter #(.DW(DW), .PKT_LEN(PKT_LEN), .IPD(IPD)) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Valid0      (Valid0),
    .Valid1      (Valid1),
    .X0          (X0),
    .X1          (X1),
    .Ready0      (Ready0),
    .Ready1      (Ready1),
    .Hold        (Hold),
    .Valid_out   (Valid_out),
    .X_out       (X_out),
    .Src_id      (Src_id),
    .Packet_Done (Packet_Done),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v0;
    bit v1;
    int late1;       // idx from which Valid1 also rises (0 = never)
    int hold_after;  // Hold asserted after this many accepts (-1 = never)
    int hold_len;
    bit flush_hold;  // Hold high throughout the flush
    int abort_at;    // stop after this many accepts (0 = run to completion)
    bit exp_src;
  } vec_t;

  typedef struct {
    logic [DW-1:0] x;
    logic          pd;
    logic          src;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(bit v0, bit v1, int late1, int ha, int hl, bit fh, int ab, bit es);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.late1 = late1; v.hold_after = ha; v.hold_len = hl;
    v.flush_hold = fh; v.abort_at = ab; v.exp_src = es;
    return v;
  endfunction

  task automatic check_outputs();
    exp_t e;
    if (Valid_out) begin
      if (q.size() == 0) begin
        chk("spurious_valid", Valid_out, 1'b0);
      end else begin
        e = q.pop_front();
        chk("x_out", X_out, e.x);
        chk("packet_done", Packet_Done, e.pd);
        chk("src_id", Src_id, e.src);
      end
    end else begin
      chk("pd_without_valid", Packet_Done, 1'b0);
    end
  endtask

  task automatic run_packet(input vec_t v);
    int            idx = 0;
    int            hu  = 0;
    int            cyc = 0;
    bit            acc;
    exp_t          e;
    logic [DW-1:0] base;
    base = v.exp_src ? DW'(16'h1000) : '0;
    forever begin
      Valid0 = v.v0;
      Valid1 = v.v1 || (v.late1 != 0 && idx >= v.late1);
      Hold   = (idx == v.hold_after && hu < v.hold_len) || (idx == PKT_LEN && v.flush_hold);
      if (idx == v.hold_after && hu < v.hold_len) hu++;
      X0 = v.exp_src ? DW'(16'hDEAD) : base + DW'(idx + 1);
      X1 = v.exp_src ? base + DW'(idx + 1) : DW'(16'hDEAD);
      #1;
      chk("ungranted_ready", v.exp_src ? Ready0 : Ready1, 1'b0);
      if (Hold) chk("ready_under_hold", v.exp_src ? Ready1 : Ready0, 1'b0);
      acc = v.exp_src ? (Valid1 && Ready1) : (Valid0 && Ready0);
      if (acc) begin
        e.x = base + DW'(idx + 1); e.pd = (idx == PKT_LEN - 1); e.src = v.exp_src;
        q.push_back(e);
        if (idx == PKT_LEN - 1)
          for (int k = 0; k < IPD; k++) begin
            e.x = '0; e.pd = 1'b0; e.src = v.exp_src;
            q.push_back(e);
          end
        idx++;
        if (v.abort_at != 0 && idx == v.abort_at) begin
          @(posedge clk); #1;
          return;
        end
      end
      @(negedge clk);
      check_outputs();
      if (idx == PKT_LEN && q.size() == 0) begin
        chk("idle_after_flush", Busy, 1'b0);
        return;
      end
      if (++cyc > 400) begin
        chk("packet_timeout", idx, PKT_LEN);
        q.delete();
        return;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, -1, 0, 0, 0, 0);   // source 0 alone, 1..12
    tbl[1]  = mk(1, 0, 0,  5, 3, 0, 0, 0);   // hold after sample 5
    tbl[2]  = mk(1, 0, 0, -1, 0, 1, 0, 0);   // hold during flush
    tbl[3]  = mk(0, 1, 0, -1, 0, 0, 0, 1);   // source 1 alone
`ifdef FIR_SHARE_RR_EN
    tbl[4]  = mk(1, 1, 0, -1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, -1, 0, 0, 0, 1);
    tbl[6]  = mk(1, 1, 0, -1, 0, 0, 0, 0);
`else
    tbl[4]  = mk(1, 1, 0, -1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, -1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, -1, 0, 0, 0, 0);
`endif
    tbl[7]  = mk(1, 0, 4, -1, 0, 0, 0, 0);   // Valid1 rises mid-packet
    tbl[8]  = mk(0, 1, 0, -1, 0, 0, 0, 1);   // source 1 served afterwards
    tbl[9]  = mk(1, 0, 0, 11, 2, 0, 0, 0);   // hold at the last accept
    tbl[10] = mk(1, 0, 0, -1, 0, 0, 7, 0);   // aborted by reset after sample 7
    tbl[11] = mk(1, 1, 0, -1, 0, 0, 0, 0);   // first contested grant after reset

    Reset_n = 1'b0; Valid0 = 1'b0; Valid1 = 1'b0; Hold = 1'b0; X0 = '0; X1 = '0;
    #3;
    chk("rst_valid_out", Valid_out, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_ready0", Ready0, 1'b0);
    chk("rst_ready1", Ready1, 1'b0);
    chk("rst_x_out", X_out, '0);
    chk("rst_src_id", Src_id, 1'b0);
    chk("rst_packet_done", Packet_Done, 1'b0);
    @(negedge clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_packet(tbl[i]);

    run_packet(tbl[10]);
    chk("pre_reset_valid", Valid_out, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("async_valid_out", Valid_out, 1'b0);
    chk("async_busy", Busy, 1'b0);
    chk("async_ready0", Ready0, 1'b0);
    chk("async_ready1", Ready1, 1'b0);
    chk("async_x_out", X_out, '0);
    chk("async_src_id", Src_id, 1'b0);
    chk("async_packet_done", Packet_Done, 1'b0);
    q.delete();
    Valid0 = 1'b0; Hold = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_valid_out", Valid_out, 1'b0);
      chk("post_reset_busy", Busy, 1'b0);
    end

    run_packet(tbl[11]);

    Valid0 = 1'b0; Valid1 = 1'b0; Hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("final_idle_valid", Valid_out, 1'b0);
      chk("final_idle_busy", Busy, 1'b0);
    end
    chk("scoreboard_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
